// File: rtl/rv32i_types.sv
// ============================================================================
// rv32i_types : shared types for the memory-port arbiter (FSM states, request)
// Revision    : 1.0
// ============================================================================
`default_nettype none

package rv32i_types;

  // Widest address the request struct can carry; narrower ports zero-extend.
  localparam int ARB_ADDR_MAX = 64;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    I_WAIT = 2'd1,
    D_WAIT = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic [ARB_ADDR_MAX-1:0] addr;
    logic [3:0]              rmask;
    logic [3:0]              wmask;
    logic [31:0]             wdata;
  } mem_req_t;

endpackage

`default_nettype wire

// File: rtl/mem_req_buffer.sv
// ============================================================================
// mem_req_buffer : single-entry pending request register with set/clear/valid
// Revision       : 1.0
// ============================================================================
`default_nettype none

module mem_req_buffer
  import rv32i_types::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     set,
  input  logic     clr,
  input  mem_req_t d,
  output mem_req_t q,
  output logic     valid
);

  // A new capture wins over a same-cycle clear so a request is never lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      q     <= '0;
    end else if (set) begin
      valid <= 1'b1;
      q     <= d;
    end else if (clr) begin
      valid <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// mem_port_arbiter : serializes fetch/data requests onto one memory port.
// Optional MEM_ARB_BYPASS_EN issues requests combinationally from empty IDLE.
// Revision         : 1.0
// ============================================================================
`default_nettype none

module mem_port_arbiter
  import rv32i_types::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic [3:0]            imem_rmask,
  output logic [31:0]           imem_rdata,
  output logic                  imem_resp,
  input  logic [ADDR_WIDTH-1:0] dmem_addr,
  input  logic [3:0]            dmem_rmask,
  input  logic [3:0]            dmem_wmask,
  input  logic [31:0]           dmem_wdata,
  output logic [31:0]           dmem_rdata,
  output logic                  dmem_resp,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [3:0]            mem_rmask,
  output logic [3:0]            mem_wmask,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata,
  input  logic                  mem_resp
);

  arb_state_t state, next_state;
  mem_req_t   i_in, d_in, i_q, d_q, issue;
  logic       i_req, d_req, i_valid, d_valid;
  logic       set_i, set_d, clr_i, clr_d, byp_i, byp_d;
  logic       unused_addr_hi;

  assign i_req = |imem_rmask;
  assign d_req = (|dmem_rmask) | (|dmem_wmask);

  assign i_in = '{addr: ARB_ADDR_MAX'(imem_addr), rmask: imem_rmask,
                  wmask: 4'b0, wdata: 32'b0};
  assign d_in = '{addr: ARB_ADDR_MAX'(dmem_addr), rmask: dmem_rmask,
                  wmask: dmem_wmask, wdata: dmem_wdata};

  // A bypassed request goes straight downstream and never occupies its buffer.
  assign set_i = i_req & ~byp_i;
  assign set_d = d_req & ~byp_d;

  mem_req_buffer u_ibuf (
    .clk   (clk),
    .rst   (rst),
    .set   (set_i),
    .clr   (clr_i),
    .d     (i_in),
    .q     (i_q),
    .valid (i_valid)
  );

  mem_req_buffer u_dbuf (
    .clk   (clk),
    .rst   (rst),
    .set   (set_d),
    .clr   (clr_d),
    .d     (d_in),
    .q     (d_q),
    .valid (d_valid)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    issue      = '0;
    clr_i      = 1'b0;
    clr_d      = 1'b0;
    byp_i      = 1'b0;
    byp_d      = 1'b0;
    imem_resp  = 1'b0;
    imem_rdata = 32'b0;
    dmem_resp  = 1'b0;
    dmem_rdata = 32'b0;
    case (state)
      IDLE: begin
        // Data side has priority; a losing fetch simply stays pending.
        if (d_valid) begin
          issue      = d_q;
          clr_d      = 1'b1;
          next_state = D_WAIT;
        end else if (i_valid) begin
          issue      = i_q;
          clr_i      = 1'b1;
          next_state = I_WAIT;
        end
`ifdef MEM_ARB_BYPASS_EN
        else if (d_req && !rst) begin
          issue      = d_in;
          byp_d      = 1'b1;
          next_state = D_WAIT;
        end else if (i_req && !rst) begin
          issue      = i_in;
          byp_i      = 1'b1;
          next_state = I_WAIT;
        end
`endif
      end
      I_WAIT: begin
        if (mem_resp) begin
          imem_resp  = 1'b1;
          imem_rdata = mem_rdata;
          next_state = IDLE;
        end
      end
      D_WAIT: begin
        if (mem_resp) begin
          dmem_resp  = 1'b1;
          dmem_rdata = mem_rdata;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  assign mem_addr       = issue.addr[ADDR_WIDTH-1:0];
  assign mem_rmask      = issue.rmask;
  assign mem_wmask      = issue.wmask;
  assign mem_wdata      = issue.wdata;
  assign unused_addr_hi = ^issue.addr;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// tb_mem_port_arbiter : directed self-checking bench for mem_port_arbiter
// Revision            : 1.0
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_addr, dmem_addr, mem_addr;
  logic [3:0]  imem_rmask, dmem_rmask, dmem_wmask, mem_rmask, mem_wmask;
  logic [31:0] imem_rdata, dmem_rdata, dmem_wdata, mem_wdata, mem_rdata;
  logic        imem_resp, dmem_resp, mem_resp;

  int total = 0;
  int bad   = 0;
  logic i_busy, d_busy;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_addr  (imem_addr),
    .imem_rmask (imem_rmask),
    .imem_rdata (imem_rdata),
    .imem_resp  (imem_resp),
    .dmem_addr  (dmem_addr),
    .dmem_rmask (dmem_rmask),
    .dmem_wmask (dmem_wmask),
    .dmem_wdata (dmem_wdata),
    .dmem_rdata (dmem_rdata),
    .dmem_resp  (dmem_resp),
    .mem_addr   (mem_addr),
    .mem_rmask  (mem_rmask),
    .mem_wmask  (mem_wmask),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_resp   (mem_resp)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to the next cycle with all request/response inputs idle.
  task automatic cyc;
    @(negedge clk);
    imem_rmask = 4'h0;
    dmem_rmask = 4'h0;
    dmem_wmask = 4'h0;
    mem_resp   = 1'b0;
  endtask

  // Protocol monitor: no second request from a side while it is still busy.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      i_busy <= 1'b0;
      d_busy <= 1'b0;
    end else begin
      if (|imem_rmask && i_busy && !imem_resp) begin
        total++;
        bad++;
        $error("FAIL proto_i observed=1 expected=0");
      end
      if ((|dmem_rmask || |dmem_wmask) && d_busy && !dmem_resp) begin
        total++;
        bad++;
        $error("FAIL proto_d observed=1 expected=0");
      end
      i_busy <= (i_busy && !imem_resp) || (|imem_rmask);
      d_busy <= (d_busy && !dmem_resp) || (|dmem_rmask) || (|dmem_wmask);
    end
  end

  initial begin
    rst = 1'b1;
    imem_addr = 32'h0; imem_rmask = 4'h0;
    dmem_addr = 32'h0; dmem_rmask = 4'h0; dmem_wmask = 4'h0; dmem_wdata = 32'h0;
    mem_rdata = 32'h0; mem_resp = 1'b0;
    cyc(); cyc();
    #1;
    chk("rst_mem_addr",  mem_addr, 32'h0);
    chk("rst_mem_rmask", {28'h0, mem_rmask}, 32'h0);
    chk("rst_mem_wmask", {28'h0, mem_wmask}, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_resps",     {30'h0, imem_resp, dmem_resp}, 32'h0);
    chk("rst_rdata",     imem_rdata | dmem_rdata, 32'h0);
    rst = 1'b0;
    cyc(); cyc();

`ifdef MEM_ARB_BYPASS_EN
    // Single fetch issued in its own cycle.
    imem_rmask = 4'hF; imem_addr = 32'h1000; #1;
    chk("byp_rmask_N", {28'h0, mem_rmask}, 32'hF);
    chk("byp_addr_N",  mem_addr, 32'h1000);
    cyc(); #1;
    chk("byp_rmask_N1", {28'h0, mem_rmask}, 32'h0);
    cyc(); mem_resp = 1'b1; mem_rdata = 32'h13; #1;
    chk("byp_iresp",  {31'h0, imem_resp}, 32'h1);
    chk("byp_irdata", imem_rdata, 32'h13);
    // Collision: D bypasses, I is buffered.
    cyc(); cyc();
    imem_rmask = 4'hF; imem_addr = 32'h1004;
    dmem_rmask = 4'h3; dmem_addr = 32'h2000; #1;
    chk("byp_col_d_rmask", {28'h0, mem_rmask}, 32'h3);
    chk("byp_col_d_addr",  mem_addr, 32'h2000);
    cyc(); mem_resp = 1'b1; mem_rdata = 32'hAAAA5555; #1;
    chk("byp_col_dresp", {30'h0, imem_resp, dmem_resp}, 32'h1);
    cyc(); #1;
    chk("byp_col_i_rmask", {28'h0, mem_rmask}, 32'hF);
    chk("byp_col_i_addr",  mem_addr, 32'h1004);
    cyc(); mem_resp = 1'b1; mem_rdata = 32'h11; #1;
    chk("byp_col_iresp", {30'h0, imem_resp, dmem_resp}, 32'h2);
    cyc();
`else
    // Single fetch.
    imem_rmask = 4'hF; imem_addr = 32'h1000; #1;
    chk("f_rmask_N", {28'h0, mem_rmask}, 32'h0);
    cyc(); #1;
    chk("f_rmask_N1", {28'h0, mem_rmask}, 32'hF);
    chk("f_addr_N1",  mem_addr, 32'h1000);
    cyc(); #1;
    chk("f_rmask_N2", {28'h0, mem_rmask}, 32'h0);
    cyc();
    cyc(); mem_resp = 1'b1; mem_rdata = 32'h00000013; #1;
    chk("f_iresp",  {31'h0, imem_resp}, 32'h1);
    chk("f_irdata", imem_rdata, 32'h13);
    chk("f_dresp",  {31'h0, dmem_resp}, 32'h0);
    cyc(); #1;
    chk("f_iresp_after", {31'h0, imem_resp}, 32'h0);

    // Collision: load wins, fetch follows after the load's response.
    cyc();
    imem_rmask = 4'hF; imem_addr = 32'h1004;
    dmem_rmask = 4'h3; dmem_addr = 32'h2000;
    cyc(); #1;
    chk("c_d_rmask", {28'h0, mem_rmask}, 32'h3);
    chk("c_d_addr",  mem_addr, 32'h2000);
    cyc(); mem_resp = 1'b1; mem_rdata = 32'hAAAA5555; #1;
    chk("c_dresp",  {30'h0, imem_resp, dmem_resp}, 32'h1);
    chk("c_drdata", dmem_rdata, 32'hAAAA5555);
    chk("c_irdata", imem_rdata, 32'h0);
    cyc(); #1;
    chk("c_i_rmask", {28'h0, mem_rmask}, 32'hF);
    chk("c_i_addr",  mem_addr, 32'h1004);
    cyc(); mem_resp = 1'b1; mem_rdata = 32'h11; #1;
    chk("c_iresp",  {30'h0, imem_resp, dmem_resp}, 32'h2);
    chk("c_drdata0", dmem_rdata, 32'h0);

    // Store.
    cyc();
    dmem_wmask = 4'hC; dmem_wdata = 32'hDEADBEEF; dmem_addr = 32'h2004;
    cyc(); #1;
    chk("s_wmask", {28'h0, mem_wmask}, 32'hC);
    chk("s_wdata", mem_wdata, 32'hDEADBEEF);
    chk("s_addr",  mem_addr, 32'h2004);
    chk("s_rmask", {28'h0, mem_rmask}, 32'h0);
    cyc(); mem_resp = 1'b1; #1;
    chk("s_wmask_gone", {28'h0, mem_wmask}, 32'h0);
    chk("s_resp", {30'h0, imem_resp, dmem_resp}, 32'h1);

    // Request on own response cycle.
    cyc();
    imem_rmask = 4'hF; imem_addr = 32'h1010;
    cyc(); #1;
    chk("o_addr1", mem_addr, 32'h1010);
    cyc(); mem_resp = 1'b1; imem_rmask = 4'hF; imem_addr = 32'h1008; #1;
    chk("o_iresp", {31'h0, imem_resp}, 32'h1);
    cyc(); #1;
    chk("o_rmask2", {28'h0, mem_rmask}, 32'hF);
    chk("o_addr2",  mem_addr, 32'h1008);
    cyc(); mem_resp = 1'b1; #1;
    chk("o_iresp2", {31'h0, imem_resp}, 32'h1);

    // Response while IDLE is ignored.
    cyc(); mem_resp = 1'b1; #1;
    chk("idle_resp", {30'h0, imem_resp, dmem_resp}, 32'h0);

    // Reset mid-transaction with a pending load, then a late response.
    cyc();
    imem_rmask = 4'hF; imem_addr = 32'h1020;
    cyc(); #1;
    chk("r_issue", mem_addr, 32'h1020);
    cyc(); dmem_rmask = 4'hF; dmem_addr = 32'h3000;
    cyc(); rst = 1'b1; #1;
    chk("r_rmask", {28'h0, mem_rmask}, 32'h0);
    chk("r_addr",  mem_addr, 32'h0);
    cyc(); rst = 1'b0; mem_resp = 1'b1; mem_rdata = 32'h55; #1;
    chk("r_late_resp", {30'h0, imem_resp, dmem_resp}, 32'h0);
    chk("r_late_rdata", imem_rdata | dmem_rdata, 32'h0);
    for (int k = 0; k < 3; k++) begin
      cyc(); #1;
      chk("r_no_issue", {24'h0, mem_rmask, mem_wmask}, 32'h0);
    end
`endif

    cyc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
